// File: rtl/mrv1_pkg.sv
// Shared constants, writeback payload type and scoreboard index helper for the MRV1 writeback path.
package mrv1_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int NUM_THREADS   = 8;
  localparam int TID_WIDTH     = $clog2(NUM_THREADS);

  typedef struct packed {
    logic [TID_WIDTH-1:0]     tid;
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  // Flat scoreboard position of a (thread, register) pair.
  function automatic logic [TID_WIDTH+RF_ADDR_WIDTH-1:0] sb_idx(
    input logic [TID_WIDTH-1:0]     tid,
    input logic [RF_ADDR_WIDTH-1:0] addr
  );
    return {tid, addr};
  endfunction

endpackage

// File: rtl/mrv1_wb_arb_if.sv
// Writeback bus: execution-unit results in, register-file write port out, issue/hazard query.
interface mrv1_wb_arb_if
  import mrv1_pkg::*;
#(
  parameter int NUM_SRC_P = 3
) ();

  logic [NUM_SRC_P-1:0]                    src_v_i;
  logic [NUM_SRC_P-1:0]                    src_ready_o;
  logic [NUM_SRC_P-1:0][TID_WIDTH-1:0]     src_tid_i;
  logic [NUM_SRC_P-1:0][RF_ADDR_WIDTH-1:0] src_addr_i;
  logic [NUM_SRC_P-1:0][DATA_WIDTH-1:0]    src_data_i;

  logic                     rd_w_en_o;
  logic [TID_WIDTH-1:0]     rd_tid_o;
  logic [RF_ADDR_WIDTH-1:0] rd_addr_o;
  logic [DATA_WIDTH-1:0]    rd_data_o;

  logic                     iss_v_i;
  logic [TID_WIDTH-1:0]     iss_tid_i;
  logic [RF_ADDR_WIDTH-1:0] iss_rd_addr_i;

  logic [TID_WIDTH-1:0]     chk_tid_i;
  logic [RF_ADDR_WIDTH-1:0] chk_rs0_addr_i;
  logic [RF_ADDR_WIDTH-1:0] chk_rs1_addr_i;
  logic [RF_ADDR_WIDTH-1:0] chk_rd_addr_i;
  logic                     chk_stall_o;

  modport slave (
    input  src_v_i, src_tid_i, src_addr_i, src_data_i,
    output src_ready_o,
    output rd_w_en_o, rd_tid_o, rd_addr_o, rd_data_o,
    input  iss_v_i, iss_tid_i, iss_rd_addr_i,
    input  chk_tid_i, chk_rs0_addr_i, chk_rs1_addr_i, chk_rd_addr_i,
    output chk_stall_o
  );

  modport master (
    output src_v_i, src_tid_i, src_addr_i, src_data_i,
    input  src_ready_o,
    input  rd_w_en_o, rd_tid_o, rd_addr_o, rd_data_o,
    output iss_v_i, iss_tid_i, iss_rd_addr_i,
    output chk_tid_i, chk_rs0_addr_i, chk_rs1_addr_i, chk_rd_addr_i,
    input  chk_stall_o
  );

endinterface

// File: rtl/mrv1_rr_arb.sv
// Round-robin arbiter: one-hot grant scanning upward from a pointer that moves just past each winner.
module mrv1_rr_arb #(
  parameter  int NUM_REQ_P = 3,
  localparam int PTR_W_LP  = $clog2(NUM_REQ_P)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ_P-1:0] req_i,
  output logic [NUM_REQ_P-1:0] grant_o
);

  localparam logic [PTR_W_LP-1:0] LAST_LP = PTR_W_LP'(NUM_REQ_P - 1);

  logic [PTR_W_LP-1:0] ptr_r;
  logic [PTR_W_LP-1:0] ptr_nxt_s;
  logic [PTR_W_LP-1:0] idx_s;
  logic [PTR_W_LP-1:0] win_s;
  logic                found_s;
  logic                take_s;

  // Scan requests from the pointer, wrapping explicitly at NUM_REQ_P (not a power of two).
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    win_s   = '0;
    idx_s   = ptr_r;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      take_s         = !found_s && req_i[idx_s];
      grant_o[idx_s] = take_s;
      win_s          = take_s ? idx_s : win_s;
      found_s        = found_s | take_s;
      idx_s          = (idx_s == LAST_LP) ? '0 : idx_s + 1'b1;
    end
    ptr_nxt_s = found_s ? ((win_s == LAST_LP) ? '0 : win_s + 1'b1) : ptr_r;
  end

  // Pointer register; only moves on a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

endmodule

// File: rtl/mrv1_wb_arb.sv
// Writeback arbiter for the barrel-threaded MRV1 core: serializes unit results onto the register
// file write port through one register stage and tracks per-thread pending writes for issue hazards.
module mrv1_wb_arb
  import mrv1_pkg::*;
#(
  parameter  int DATA_WIDTH_P    = DATA_WIDTH,
  parameter  int NUM_THREADS_P   = NUM_THREADS,
  parameter  int NUM_SRC_P       = 3,
  parameter  int rf_addr_width_p = RF_ADDR_WIDTH,
  localparam int TID_WIDTH_LP    = $clog2(NUM_THREADS_P)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mrv1_wb_arb_if.slave bus
);

  localparam int SB_DEPTH_LP = NUM_THREADS_P * (2 ** rf_addr_width_p);

  logic [NUM_SRC_P-1:0]       req_s;
  logic [NUM_SRC_P-1:0]       grant_s;
  logic                       hs_s;
  wb_req_t                    sel_s;
  logic                       w_en_r;
  logic [TID_WIDTH_LP-1:0]    tid_r;
  logic [rf_addr_width_p-1:0] addr_r;
  logic [DATA_WIDTH_P-1:0]    data_r;
  logic [SB_DEPTH_LP-1:0]     pend_r;
  logic [SB_DEPTH_LP-1:0]     pend_nxt_s;
  logic [SB_DEPTH_LP-1:0]     clr_mask_s;
  logic [SB_DEPTH_LP-1:0]     set_mask_s;
  logic                       set_v_s;

  // Register 0 is never tracked, so it can never cause a stall.
  function automatic logic pend_hit(
    input logic [SB_DEPTH_LP-1:0]     pend,
    input logic [TID_WIDTH_LP-1:0]    tid,
    input logic [rf_addr_width_p-1:0] addr
  );
    return (addr != '0) && pend[sb_idx(tid, addr)];
  endfunction

  // Nothing is granted while reset is held, which also keeps the pointer at 0.
  assign req_s = rst_i ? '0 : bus.src_v_i;

  mrv1_rr_arb #(
    .NUM_REQ_P (NUM_SRC_P)
  ) u_rr_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_s),
    .grant_o (grant_s)
  );

  assign bus.src_ready_o = grant_s;
  assign hs_s            = |grant_s;

  // Payload mux for the single granted source.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NUM_SRC_P; i++) begin
      if (grant_s[i]) begin
        sel_s.tid  = bus.src_tid_i[i];
        sel_s.addr = bus.src_addr_i[i];
        sel_s.data = bus.src_data_i[i];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Output write stage; results for x0 are consumed without a write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_en_r <= 1'b0;
      tid_r  <= '0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      w_en_r <= hs_s && (sel_s.addr != '0);
      if (hs_s) begin
        tid_r  <= sel_s.tid;
        addr_r <= sel_s.addr;
        data_r <= sel_s.data;
      end
    end
  end

  assign bus.rd_w_en_o = w_en_r;
  assign bus.rd_tid_o  = tid_r;
  assign bus.rd_addr_o = addr_r;
  assign bus.rd_data_o = data_r;

  // Scoreboard next state: clear the bit being written back, then set the issued one so set wins.
  always_comb begin
    set_v_s    = bus.iss_v_i && (bus.iss_rd_addr_i != '0);
    clr_mask_s = {{(SB_DEPTH_LP-1){1'b0}}, w_en_r} << sb_idx(tid_r, addr_r);
    set_mask_s = {{(SB_DEPTH_LP-1){1'b0}}, set_v_s} << sb_idx(bus.iss_tid_i, bus.iss_rd_addr_i);
    pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // No bypass of the clear: the operand stays hazardous while its write is on rd_*.
  assign bus.chk_stall_o = pend_hit(pend_r, bus.chk_tid_i, bus.chk_rs0_addr_i)
                         | pend_hit(pend_r, bus.chk_tid_i, bus.chk_rs1_addr_i)
                         | pend_hit(pend_r, bus.chk_tid_i, bus.chk_rd_addr_i);

endmodule

// File: tb/tb_mrv1_wb_arb.sv
// Randomized scoreboard bench for mrv1_wb_arb: directed scenarios, then random traffic, checked
// against a reference model built from round-robin/latency/pending-write rules.
`timescale 1ns/1ps
module tb_mrv1_wb_arb;
  import mrv1_pkg::*;

  localparam int NS = 3;
  localparam int TW = TID_WIDTH;
  localparam int AW = RF_ADDR_WIDTH;

  typedef struct {
    int                    cyc;
    logic [TW-1:0]         tid;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  mrv1_wb_arb_if #(.NUM_SRC_P(NS)) bus ();

  mrv1_wb_arb #(.NUM_SRC_P(NS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus state
  logic [NS-1:0]         s_v = '0;
  logic [TW-1:0]         s_tid  [NS];
  logic [AW-1:0]         s_addr [NS];
  logic [DATA_WIDTH-1:0] s_data [NS];
  logic                  i_v = 1'b0;
  logic [TW-1:0]         i_tid = '0;
  logic [AW-1:0]         i_rd = '0;
  logic [TW-1:0]         c_tid = '0;
  logic [AW-1:0]         c_rs0 = '0, c_rs1 = '0, c_rd = '0;
  logic                  r = 1'b1;
  int                    last_g = -1;

  // Reference model state
  int            m_ptr = 0;
  bit            m_pend [NUM_THREADS][2**AW];
  bit            m_wr_v = 1'b0;
  logic [TW-1:0] m_wr_tid = '0;
  logic [AW-1:0] m_wr_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_hit(input logic [TW-1:0] t, input logic [AW-1:0] a);
    return (a != '0) && m_pend[t][a];
  endfunction

  task automatic new_payload(input int i);
    s_tid[i]  = TW'($urandom_range(NUM_THREADS - 1));
    s_addr[i] = AW'($urandom_range(7));
    s_data[i] = $urandom;
  endtask

  // One cycle: drive at negedge, check combinational outputs, predict writes, advance the model.
  task automatic step();
    int            g;
    logic [NS-1:0] want_rdy;
    bit            want_stall;
    @(negedge clk);
    rst         = r;
    bus.src_v_i = s_v;
    for (int i = 0; i < NS; i++) begin
      bus.src_tid_i[i]  = s_tid[i];
      bus.src_addr_i[i] = s_addr[i];
      bus.src_data_i[i] = s_data[i];
    end
    bus.iss_v_i        = i_v;
    bus.iss_tid_i      = i_tid;
    bus.iss_rd_addr_i  = i_rd;
    bus.chk_tid_i      = c_tid;
    bus.chk_rs0_addr_i = c_rs0;
    bus.chk_rs1_addr_i = c_rs1;
    bus.chk_rd_addr_i  = c_rd;
    #1;
    g = -1;
    if (!r) begin
      for (int k = 0; k < NS; k++) begin
        if (g < 0 && s_v[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
      end
    end
    want_rdy = '0;
    if (g >= 0) want_rdy[g] = 1'b1;
    want_stall = m_hit(c_tid, c_rs0) || m_hit(c_tid, c_rs1) || m_hit(c_tid, c_rd);
    check("src_ready", 64'(bus.src_ready_o), 64'(want_rdy));
    check("chk_stall", 64'(bus.chk_stall_o), 64'(want_stall));
    if (g >= 0 && s_addr[g] != '0) exp_q.push_back('{cyc + 1, s_tid[g], s_addr[g], s_data[g]});
    @(posedge clk);
    if (r) begin
      m_ptr  = 0;
      m_wr_v = 1'b0;
      foreach (m_pend[t, a]) m_pend[t][a] = 1'b0;
    end else begin
      if (m_wr_v) m_pend[m_wr_tid][m_wr_addr] = 1'b0;
      if (i_v && i_rd != '0) m_pend[i_tid][i_rd] = 1'b1;
      m_wr_v = (g >= 0) && (s_addr[g] != '0);
      if (g >= 0) begin
        m_wr_tid  = s_tid[g];
        m_wr_addr = s_addr[g];
        m_ptr     = (g + 1) % NS;
      end
    end
    last_g = g;
  endtask

  // Monitor: every cycle the write port must match the head of the expected-write queue.
  initial begin
    exp_t e;
    bit   want;
    @(posedge clk);
    forever begin
      @(negedge clk);
      want = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("rd_w_en", 64'(bus.rd_w_en_o), 64'(want));
      if (want) begin
        e = exp_q.pop_front();
        if (bus.rd_w_en_o === 1'b1) begin
          check("rd_tid", 64'(bus.rd_tid_o), 64'(e.tid));
          check("rd_addr", 64'(bus.rd_addr_o), 64'(e.addr));
          check("rd_data", 64'(bus.rd_data_o), 64'(e.data));
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL rd_missing: write for cycle %0d never appeared (now %0d)", e.cyc, cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NS; i++) new_payload(i);

    // Reset with all sources requesting, then first grant goes to source 0
    r   = 1'b1;
    s_v = '1;
    repeat (3) step();
    r = 1'b0;
    step();
    if (last_g >= 0) new_payload(last_g);

    // Continuous requests rotate 1,2,0,1,2,0
    repeat (6) begin
      step();
      if (last_g >= 0) new_payload(last_g);
    end
    s_v = '0;
    step();

    // Single source with a known payload
    s_v       = 3'b010;
    s_tid[1]  = 3'd3;
    s_addr[1] = 5'd7;
    s_data[1] = 32'hDEAD_BEEF;
    step();
    s_v = '0;
    step();

    // RAW hazard on (2,5), cleared one cycle after its writeback; thread 1 never stalls
    i_v   = 1'b1;
    i_tid = 3'd2;
    i_rd  = 5'd5;
    step();
    i_v   = 1'b0;
    c_tid = 3'd1;
    c_rs0 = 5'd5;
    step();
    c_tid = 3'd2;
    step();
    s_v       = 3'b001;
    s_tid[0]  = 3'd2;
    s_addr[0] = 5'd5;
    s_data[0] = $urandom;
    step();
    s_v = '0;
    step();
    step();
    c_tid = 3'd1;
    step();

    // x0 result is consumed without a write; rs0=0 never stalls
    s_v       = 3'b100;
    s_tid[2]  = 3'd2;
    s_addr[2] = 5'd0;
    c_rs0     = 5'd0;
    step();
    s_v = '0;
    step();

    // Re-issue of (4,9) on the cycle its write is on rd_*: the bit stays set
    i_v   = 1'b1;
    i_tid = 3'd4;
    i_rd  = 5'd9;
    step();
    i_v   = 1'b0;
    c_tid = 3'd4;
    c_rd  = 5'd9;
    s_v       = 3'b001;
    s_tid[0]  = 3'd4;
    s_addr[0] = 5'd9;
    s_data[0] = $urandom;
    step();
    s_v = '0;
    i_v = 1'b1;
    step();
    i_v = 1'b0;
    step();
    step();
    s_v       = 3'b010;
    s_tid[1]  = 3'd4;
    s_addr[1] = 5'd9;
    s_data[1] = $urandom;
    step();
    s_v = '0;
    step();
    step();
    c_rd = '0;

    // Random traffic with sources holding until accepted and occasional mid-run reset
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) begin
        if (!s_v[i] || last_g == i) begin
          s_v[i] = ($urandom_range(99) < 60);
          new_payload(i);
        end
      end
      r     = ($urandom_range(199) == 0);
      i_v   = ($urandom_range(99) < 40);
      i_tid = TW'($urandom_range(NUM_THREADS - 1));
      i_rd  = AW'($urandom_range(7));
      c_tid = TW'($urandom_range(NUM_THREADS - 1));
      c_rs0 = AW'($urandom_range(7));
      c_rs1 = AW'($urandom_range(7));
      c_rd  = AW'($urandom_range(7));
      step();
    end

    s_v = '0;
    i_v = 1'b0;
    r   = 1'b0;
    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
